// File: rtl/ps2_key_framer.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_key_framer
//  Purpose  : PS/2 keyboard receiver that deserialises 11-bit device frames,
//             groups scan-code bytes into complete key sequences and
//             publishes each sequence on a 65-bit toggle-strobed event bus.
//  Ports    : clk_sys    - system clock (sole clock domain)
//             reset      - asynchronous active-high reset
//             ps2_clk    - raw PS/2 clock line (asynchronous)
//             ps2_data   - raw PS/2 data line (asynchronous)
//             ps2_key    - [64] toggle strobe, [63:0] sequence bytes,
//                          newest byte in [7:0], unused upper bytes zero
//             frame_err  - one-cycle pulse on start/parity/stop/timeout error
//             busy       - high while a frame or multi-byte sequence is open
//  Params   : FILTER_LEN  - cycles a synchronised ps2_clk level must hold
//             TIMEOUT_CYC - idle cycles before partial data is dropped
//  Options  : PS2_TYPEMATIC_FILTER_EN - when defined, auto-repeated make
//             codes of a held key are suppressed until its break arrives.
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_key_framer #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 24000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [64:0] ps2_key,
    output logic        frame_err,
    output logic        busy
);

    localparam int FW = (FILTER_LEN  > 1) ? $clog2(FILTER_LEN + 1)  : 1;
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);

    // ------------------------------------------------------------------
    // Input synchronisers. Reset to the idle-high line level so that a
    // reset never manufactures a falling edge.
    // ------------------------------------------------------------------
    logic [1:0] clk_sync_q;
    logic [1:0] data_sync_q;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk};
            data_sync_q <= {data_sync_q[0], ps2_data};
        end
    end

    // ------------------------------------------------------------------
    // Glitch filter: the filtered clock follows the synchronised clock
    // only after FILTER_LEN consecutive samples disagree with it. The
    // data line is captured at the moment the filtered clock moves, so
    // bit_q is the data value belonging to that edge.
    // ------------------------------------------------------------------
    logic          clk_filt_q;
    logic [FW-1:0] filt_cnt_q;
    logic          fall_q;      // filtered falling edge, one-cycle pulse
    logic          edge_q;      // any filtered edge, one-cycle pulse
    logic          bit_q;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            clk_filt_q <= 1'b1;
            filt_cnt_q <= '0;
            fall_q     <= 1'b0;
            edge_q     <= 1'b0;
            bit_q      <= 1'b1;
        end else begin
            fall_q <= 1'b0;
            edge_q <= 1'b0;
            if (clk_sync_q[1] == clk_filt_q) begin
                filt_cnt_q <= '0;
            end else if (filt_cnt_q == FILT_LAST) begin
                clk_filt_q <= clk_sync_q[1];
                filt_cnt_q <= '0;
                edge_q     <= 1'b1;
                fall_q     <= ~clk_sync_q[1];
                bit_q      <= data_sync_q[1];
            end else begin
                filt_cnt_q <= filt_cnt_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame receiver
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_t;

    rx_state_t     rx_state_q;
    logic [7:0]    rx_shift_q;
    logic [2:0]    rx_bits_q;
    logic          rx_par_ok_q;
    logic [TW-1:0] rx_to_q;
    logic [7:0]    byte_q;
    logic          byte_vld_q;
    logic          rx_flush_q;   // parity/stop failure: assembler must restart
    logic          frame_err_q;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            rx_state_q  <= RX_IDLE;
            rx_shift_q  <= '0;
            rx_bits_q   <= '0;
            rx_par_ok_q <= 1'b0;
            rx_to_q     <= '0;
            byte_q      <= '0;
            byte_vld_q  <= 1'b0;
            rx_flush_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            byte_vld_q  <= 1'b0;
            rx_flush_q  <= 1'b0;
            frame_err_q <= 1'b0;

            // Inter-edge watchdog; only meaningful once a frame has started.
            if (edge_q || (rx_state_q == RX_IDLE)) begin
                rx_to_q <= '0;
            end else if (rx_to_q == TO_LAST) begin
                rx_to_q     <= '0;
                rx_state_q  <= RX_IDLE;
                frame_err_q <= 1'b1;
            end else begin
                rx_to_q <= rx_to_q + 1'b1;
            end

            if (fall_q) begin
                case (rx_state_q)
                    RX_IDLE: begin
                        if (!bit_q) begin
                            rx_state_q <= RX_DATA;
                            rx_bits_q  <= '0;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end
                    RX_DATA: begin
                        rx_shift_q <= {bit_q, rx_shift_q[7:1]};
                        rx_bits_q  <= rx_bits_q + 3'd1;
                        if (rx_bits_q == 3'd7) begin
                            rx_state_q <= RX_PARITY;
                        end
                    end
                    RX_PARITY: begin
                        rx_par_ok_q <= ^{rx_shift_q, bit_q};
                        rx_state_q  <= RX_STOP;
                    end
                    RX_STOP: begin
                        rx_state_q <= RX_IDLE;
                        if (bit_q && rx_par_ok_q) begin
                            byte_q     <= rx_shift_q;
                            byte_vld_q <= 1'b1;
                        end else begin
                            frame_err_q <= 1'b1;
                            rx_flush_q  <= 1'b1;
                        end
                    end
                    default: rx_state_q <= RX_IDLE;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequence assembler
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        AS_EMPTY = 2'd0,
        AS_OPEN  = 2'd1,
        AS_PAUSE = 2'd2
    } as_state_t;

    as_state_t     as_state_q;
    as_state_t     as_state_d;
    logic [55:0]   seq_q;        // older bytes; the newest arrives in byte_q
    logic [63:0]   seq_d;
    logic [3:0]    cnt_q;
    logic [3:0]    cnt_d;
    logic [TW-1:0] as_to_q;
    logic [64:0]   key_q;
    logic          seq_hold;     // sequence continues after this byte
    logic          typematic_drop;

    always_comb begin
        seq_d      = {seq_q, byte_q};
        cnt_d      = (cnt_q == 4'd8) ? 4'd8 : cnt_q + 4'd1;
        seq_hold   = 1'b0;
        as_state_d = AS_EMPTY;
        if (cnt_d == 4'd8) begin
            // Eighth byte always closes the sequence.
            seq_hold = 1'b0;
        end else if (as_state_q == AS_PAUSE) begin
            seq_hold   = 1'b1;
            as_state_d = AS_PAUSE;
        end else if ((as_state_q == AS_EMPTY) && (byte_q == 8'hE1)) begin
            seq_hold   = 1'b1;
            as_state_d = AS_PAUSE;
        end else if ((byte_q == 8'hE0) || (byte_q == 8'hF0)) begin
            seq_hold   = 1'b1;
            as_state_d = AS_OPEN;
        end else if (((cnt_d == 4'd2) && (seq_d[15:0] == 16'hE012)) ||
                     ((cnt_d == 4'd3) && (seq_d[23:0] == 24'hE0F07C))) begin
            // Print-screen make/break are two glued extended codes.
            seq_hold   = 1'b1;
            as_state_d = AS_OPEN;
        end
    end

`ifdef PS2_TYPEMATIC_FILTER_EN
    logic        held_q;
    logic [63:0] last_make_q;
    logic        is_make;
    logic        is_break;
    logic [63:0] break_make;

    always_comb begin
        is_make        = (cnt_d == 4'd1) ||
                         ((cnt_d == 4'd2) && (seq_d[15:8] == 8'hE0));
        is_break       = ((cnt_d == 4'd2) && (seq_d[15:8] == 8'hF0)) ||
                         ((cnt_d == 4'd3) && (seq_d[23:8] == 16'hE0F0));
        // Make code that a given break code releases.
        break_make     = (cnt_d == 4'd3) ? {48'h0, 8'hE0, byte_q} : {56'h0, byte_q};
        typematic_drop = is_make && held_q && (seq_d == last_make_q);
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            held_q      <= 1'b0;
            last_make_q <= '0;
        end else if (byte_vld_q && !seq_hold) begin
            if (is_make && !typematic_drop) begin
                last_make_q <= seq_d;
                held_q      <= 1'b1;
            end else if (is_break && (break_make == last_make_q)) begin
                held_q <= 1'b0;
            end
        end
    end
`else
    assign typematic_drop = 1'b0;
`endif

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            as_state_q <= AS_EMPTY;
            seq_q      <= '0;
            cnt_q      <= '0;
            as_to_q    <= '0;
            key_q      <= '0;
        end else if (rx_flush_q) begin
            as_state_q <= AS_EMPTY;
            seq_q      <= '0;
            cnt_q      <= '0;
            as_to_q    <= '0;
        end else if (byte_vld_q) begin
            // A byte arriving on the timeout cycle takes priority.
            as_to_q <= '0;
            if (seq_hold) begin
                seq_q      <= seq_d[55:0];
                cnt_q      <= cnt_d;
                as_state_q <= as_state_d;
            end else begin
                seq_q      <= '0;
                cnt_q      <= '0;
                as_state_q <= AS_EMPTY;
                if (!typematic_drop) begin
                    key_q <= {~key_q[64], seq_d};
                end
            end
        end else if (as_state_q != AS_EMPTY) begin
            if (as_to_q == TO_LAST) begin
                // Stale partial sequence is discarded without an error.
                as_state_q <= AS_EMPTY;
                seq_q      <= '0;
                cnt_q      <= '0;
                as_to_q    <= '0;
            end else begin
                as_to_q <= as_to_q + 1'b1;
            end
        end
    end

    assign ps2_key   = key_q;
    assign frame_err = frame_err_q;
    assign busy      = (rx_state_q != RX_IDLE) | (as_state_q != AS_EMPTY);

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_framer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ps2_key_framer
//  Purpose  : Self-checking bench for ps2_key_framer. Drives PS/2 frames,
//             collects every published event and compares against constants
//             and a byte-queue reference model of the sequence rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_key_framer;

    localparam int FILTER_LEN  = 8;
    localparam int TIMEOUT_CYC = 2000;
    localparam int HP          = 20;   // PS/2 half period in clk_sys cycles

    logic        clk_sys  = 1'b0;
    logic        reset    = 1'b1;
    logic        ps2_clk  = 1'b1;
    logic        ps2_data = 1'b1;
    logic [64:0] ps2_key;
    logic        frame_err;
    logic        busy;

    ps2_key_framer #(
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .ps2_key   (ps2_key),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk_sys = ~clk_sys;

    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc      = 0;

    always @(posedge clk_sys) cyc <= cyc + 1;

    // ---------------- event monitor ----------------
    logic        prev64 = 1'b0;
    logic [63:0] obs_q[$];
    int unsigned last_toggle_cyc = 0;
    int          err_cnt = 0;
    int unsigned stop_cyc = 0;
    logic        busy_mid = 1'b0;

    always @(negedge clk_sys) begin
        if (reset) begin
            prev64 = ps2_key[64];
        end else begin
            if (ps2_key[64] !== prev64) begin
                obs_q.push_back(ps2_key[63:0]);
                last_toggle_cyc = cyc;
                prev64 = ps2_key[64];
            end
            if (frame_err === 1'b1) err_cnt++;
        end
    end

    // ---------------- reference model ----------------
    logic [7:0]  cur_q[$];
    logic [63:0] exp_q[$];
    logic [63:0] m_last = '0;
    bit          m_held = 1'b0;

    task automatic model_byte(input logic [7:0] b);
        int          n;
        bit          open;
        logic [63:0] v;
        cur_q.push_back(b);
        n    = cur_q.size();
        open = 1'b0;
        if (n < 8) begin
            if (cur_q[0] == 8'hE1) open = 1'b1;
            else if (b == 8'hE0 || b == 8'hF0) open = 1'b1;
            else if (n == 2 && cur_q[0] == 8'hE0 && b == 8'h12) open = 1'b1;
            else if (n == 3 && cur_q[0] == 8'hE0 && cur_q[1] == 8'hF0 && b == 8'h7C) open = 1'b1;
        end
        if (!open) begin
            bit mk, br, drop;
            v = '0;
            foreach (cur_q[i]) v = {v[55:0], cur_q[i]};
            mk   = (n == 1) || (n == 2 && cur_q[0] == 8'hE0);
            br   = (n == 2 && cur_q[0] == 8'hF0) || (n == 3 && cur_q[0] == 8'hE0 && cur_q[1] == 8'hF0);
            drop = 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
            if (mk && m_held && v == m_last) drop = 1'b1;
            else if (mk) begin
                m_last = v;
                m_held = 1'b1;
            end else if (br) begin
                logic [63:0] bm;
                bm = (n == 3) ? {48'h0, 8'hE0, b} : {56'h0, b};
                if (bm == m_last) m_held = 1'b0;
            end
`endif
            if (!drop) exp_q.push_back(v);
            cur_q.delete();
        end
    endtask

    // ---------------- stimulus helpers ----------------
    // Sends the first nbits of a frame (11 for a full frame).
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits);
        logic [10:0] bits;
        bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk_sys);
            ps2_data = bits[i];
            repeat (HP) @(negedge clk_sys);
            ps2_clk = 1'b0;
            if (i == 10) stop_cyc = cyc;
            repeat (HP) @(negedge clk_sys);
            if (i == 0) busy_mid = busy;
            ps2_clk = 1'b1;
        end
        @(negedge clk_sys);
        ps2_data = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b0, 11);
        model_byte(b);
        repeat ($urandom_range(0, 3) * HP) @(negedge clk_sys);
    endtask

    task automatic do_reset();
        @(posedge clk_sys);
        #3 reset = 1'b1;
        repeat (3) @(negedge clk_sys);
        reset = 1'b0;
        cur_q.delete();
        m_held = 1'b0;
        m_last = '0;
        repeat (5) @(negedge clk_sys);
        obs_q.delete();
        exp_q.delete();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (4) @(negedge clk_sys);
        checks++; if (ps2_key !== 65'h0) begin failures++; $display("FAIL reset_key: got %h expected %h", ps2_key, 65'h0); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", frame_err); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        reset = 1'b0;
        repeat (5) @(negedge clk_sys);
    endtask

    task automatic test_single_byte();
        int e0, lat;
        e0 = err_cnt;
        obs_q.delete();
        send_frame(8'h1C, 1'b0, 11);
        repeat (10) @(negedge clk_sys);
        lat = int'(last_toggle_cyc - stop_cyc);
        checks++; if (obs_q.size() != 1) begin failures++; $display("FAIL single_count: got %0d expected 1", obs_q.size()); end
        checks++; if (obs_q.size() < 1 || obs_q[0] !== 64'h1C) begin failures++; $display("FAIL single_value: got %h expected %h", ps2_key[63:0], 64'h1C); end
        checks++; if (ps2_key[64] !== 1'b1) begin failures++; $display("FAIL single_toggle: got %b expected 1", ps2_key[64]); end
        checks++; if (err_cnt != e0) begin failures++; $display("FAIL single_err: got %0d expected %0d", err_cnt, e0); end
        checks++; if (lat < FILTER_LEN + 2 || lat > FILTER_LEN + 6) begin failures++; $display("FAIL single_latency: got %0d expected %0d..%0d", lat, FILTER_LEN + 2, FILTER_LEN + 6); end
    endtask

    task automatic test_ext_break();
        logic b_first, b_between;
        obs_q.delete();
        send_frame(8'hE0, 1'b0, 11);
        b_first = busy_mid;
        repeat (HP) @(negedge clk_sys);
        b_between = busy;
        checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL ext_early_publish: got %0d expected 0", obs_q.size()); end
        send_frame(8'hF0, 1'b0, 11);
        send_frame(8'h6B, 1'b0, 11);
        repeat (10) @(negedge clk_sys);
        checks++; if (b_first !== 1'b1) begin failures++; $display("FAIL ext_busy_frame: got %b expected 1", b_first); end
        checks++; if (b_between !== 1'b1) begin failures++; $display("FAIL ext_busy_open: got %b expected 1", b_between); end
        checks++; if (obs_q.size() != 1) begin failures++; $display("FAIL ext_count: got %0d expected 1", obs_q.size()); end
        checks++; if (ps2_key[63:0] !== 64'h0000_0000_00E0_F06B) begin failures++; $display("FAIL ext_value: got %h expected %h", ps2_key[63:0], 64'hE0F06B); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ext_busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_pause_prtscr();
        logic [7:0] pause_b [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        logic [7:0] prt_b [4]   = '{8'hE0, 8'h12, 8'hE0, 8'h7C};
        obs_q.delete();
        foreach (pause_b[i]) send_frame(pause_b[i], 1'b0, 11);
        repeat (10) @(negedge clk_sys);
        checks++; if (obs_q.size() != 1) begin failures++; $display("FAIL pause_count: got %0d expected 1", obs_q.size()); end
        checks++; if (ps2_key[63:0] !== 64'hE114_77E1_F014_F077) begin failures++; $display("FAIL pause_value: got %h expected %h", ps2_key[63:0], 64'hE114_77E1_F014_F077); end
        obs_q.delete();
        foreach (prt_b[i]) send_frame(prt_b[i], 1'b0, 11);
        repeat (10) @(negedge clk_sys);
        checks++; if (obs_q.size() != 1) begin failures++; $display("FAIL prtscr_count: got %0d expected 1", obs_q.size()); end
        checks++; if (ps2_key[63:0] !== 64'hE012_E07C) begin failures++; $display("FAIL prtscr_value: got %h expected %h", ps2_key[63:0], 64'hE012_E07C); end
    endtask

    task automatic test_parity_err();
        int e0;
        e0 = err_cnt;
        obs_q.delete();
        send_frame(8'h29, 1'b1, 11);
        repeat (10) @(negedge clk_sys);
        checks++; if (err_cnt != e0 + 1) begin failures++; $display("FAIL parity_err_pulse: got %0d expected %0d", err_cnt, e0 + 1); end
        checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL parity_no_toggle: got %0d expected 0", obs_q.size()); end
        send_frame(8'h29, 1'b0, 11);
        repeat (10) @(negedge clk_sys);
        checks++; if (obs_q.size() != 1 || ps2_key[63:0] !== 64'h29) begin failures++; $display("FAIL parity_recover: got %0d events value %h expected 1 events value %h", obs_q.size(), ps2_key[63:0], 64'h29); end
        // A bad frame inside a sequence restarts the assembler.
        obs_q.delete();
        send_frame(8'hE0, 1'b0, 11);
        send_frame(8'h33, 1'b1, 11);
        send_frame(8'h1C, 1'b0, 11);
        repeat (10) @(negedge clk_sys);
        checks++; if (obs_q.size() != 1 || ps2_key[63:0] !== 64'h1C) begin failures++; $display("FAIL parity_flush: got %0d events value %h expected 1 events value %h", obs_q.size(), ps2_key[63:0], 64'h1C); end
        checks++; if (err_cnt != e0 + 2) begin failures++; $display("FAIL parity_err_total: got %0d expected %0d", err_cnt, e0 + 2); end
    endtask

    task automatic test_timeout();
        int e0;
        e0 = err_cnt;
        obs_q.delete();
        send_frame(8'h55, 1'b0, 6);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL timeout_busy_mid: got %b expected 1", busy); end
        repeat (TIMEOUT_CYC + 100) @(negedge clk_sys);
        checks++; if (err_cnt != e0 + 1) begin failures++; $display("FAIL timeout_err: got %0d expected %0d", err_cnt, e0 + 1); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL timeout_busy: got %b expected 0", busy); end
        send_frame(8'h14, 1'b0, 11);
        repeat (10) @(negedge clk_sys);
        checks++; if (obs_q.size() != 1 || ps2_key[63:0] !== 64'h14) begin failures++; $display("FAIL timeout_recover: got %0d events value %h expected 1 events value %h", obs_q.size(), ps2_key[63:0], 64'h14); end
        // Stale prefix is dropped silently.
        e0 = err_cnt;
        obs_q.delete();
        send_frame(8'hE0, 1'b0, 11);
        repeat (TIMEOUT_CYC + 100) @(negedge clk_sys);
        checks++; if (busy !== 1'b0 || err_cnt != e0) begin failures++; $display("FAIL asm_timeout: got busy %b errs %0d expected busy 0 errs %0d", busy, err_cnt, e0); end
        send_frame(8'h1C, 1'b0, 11);
        repeat (10) @(negedge clk_sys);
        checks++; if (obs_q.size() != 1 || ps2_key[63:0] !== 64'h1C) begin failures++; $display("FAIL asm_timeout_recover: got %0d events value %h expected 1 events value %h", obs_q.size(), ps2_key[63:0], 64'h1C); end
    endtask

    task automatic test_reset_mid();
        send_frame(8'h33, 1'b0, 4);
        @(posedge clk_sys);
        #3 reset = 1'b1;
        #1;
        checks++; if (ps2_key !== 65'h0 || frame_err !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL reset_mid: got key %h err %b busy %b expected all 0", ps2_key, frame_err, busy); end
        repeat (3) @(negedge clk_sys);
        reset = 1'b0;
        obs_q.delete();
        repeat (100) @(negedge clk_sys);
        checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL reset_mid_toggle: got %0d expected 0", obs_q.size()); end
        send_frame(8'h1C, 1'b0, 11);
        repeat (10) @(negedge clk_sys);
        checks++; if (obs_q.size() != 1 || ps2_key !== {1'b1, 64'h1C}) begin failures++; $display("FAIL reset_mid_recover: got %0d events key %h expected 1 events key %h", obs_q.size(), ps2_key, {1'b1, 64'h1C}); end
    endtask

    task automatic test_repeat();
        do_reset();
        for (int i = 0; i < 3; i++) send_frame(8'h1C, 1'b0, 11);
        repeat (10) @(negedge clk_sys);
`ifdef PS2_TYPEMATIC_FILTER_EN
        checks++; if (obs_q.size() != 1) begin failures++; $display("FAIL typematic_drop: got %0d expected 1", obs_q.size()); end
        send_frame(8'hF0, 1'b0, 11);
        send_frame(8'h1C, 1'b0, 11);
        repeat (10) @(negedge clk_sys);
        checks++; if (obs_q.size() != 2 || ps2_key[63:0] !== 64'hF01C) begin failures++; $display("FAIL typematic_break: got %0d events value %h expected 2 events value %h", obs_q.size(), ps2_key[63:0], 64'hF01C); end
        send_frame(8'h1C, 1'b0, 11);
        repeat (10) @(negedge clk_sys);
        checks++; if (obs_q.size() != 3 || ps2_key[63:0] !== 64'h1C) begin failures++; $display("FAIL typematic_remake: got %0d events value %h expected 3 events value %h", obs_q.size(), ps2_key[63:0], 64'h1C); end
`else
        checks++; if (obs_q.size() != 3) begin failures++; $display("FAIL repeat_count: got %0d expected 3", obs_q.size()); end
        checks++; if (ps2_key !== {1'b1, 64'h1C}) begin failures++; $display("FAIL repeat_value: got %h expected %h", ps2_key, {1'b1, 64'h1C}); end
`endif
    endtask

    task automatic test_random();
        int          kind;
        logic [7:0]  k;
        logic [7:0]  last_k;
        int          n;
        do_reset();
        last_k = 8'h1C;
        for (int s = 0; s < 20; s++) begin
            kind = $urandom_range(0, 5);
            k    = 8'($urandom_range(1, 8'h7F));
            if (k == 8'h12 || k == 8'h7C) k = 8'h1C;
            case (kind)
                0: begin send_byte(k); last_k = k; end
                1: send_byte(last_k);
                2: begin send_byte(8'hF0); send_byte(k); end
                3: begin send_byte(8'hE0); send_byte(k); end
                4: begin send_byte(8'hE0); send_byte(8'hF0); send_byte(k); end
                default: begin
                    send_byte(8'hE1);
                    for (int j = 0; j < 7; j++) send_byte(8'($urandom_range(0, 255)));
                end
            endcase
        end
        repeat (20) @(negedge clk_sys);
        checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL random_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL random_value[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL random_busy: got %b expected 0", busy); end
    endtask

    initial begin
        #(95000 * 10);
        $display("FAIL watchdog: got no completion expected completion within 95000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_byte();
        test_ext_break();
        test_pause_prtscr();
        test_parity_err();
        test_timeout();
        test_reset_mid();
        test_repeat();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
